// File: rtl/sram_rr_arbiter_pkg.sv
// Shared definitions for the SRAM-like round-robin arbiter.
// Holds the FSM state encoding and the SRAM transfer size codes.
package sram_rr_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/sram_rr_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Returns the first set request at or after the pointer, wrapping past the last channel.
module sram_rr_arbiter_rr_pick #(
    parameter int N_CH = 2,
    parameter int IW   = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic [IW-1:0]   o_idx,
    output logic            o_valid
);

    logic [IW-1:0] w_cand;

    // Scan from the farthest offset down so the nearest requester wins last
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        for (int off = N_CH - 1; off >= 0; off--) begin
            w_cand = IW'((int'(i_ptr) + off) % N_CH);
            if (i_req[w_cand]) begin
                o_idx   = w_cand;
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter muxing N_CH SRAM-like masters onto one SRAM-like slave.
// One transaction in flight at a time; the grant is held from ADDR entry to DATA exit.
module sram_rr_arbiter
    import sram_rr_arbiter_pkg::*;
#(
    parameter int N_CH = 2,
    parameter int AW   = 32,
    parameter int DW   = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_CH-1:0]    m_req,
    input  logic [N_CH-1:0]    m_wr,
    input  logic [2*N_CH-1:0]  m_size,
    input  logic [AW*N_CH-1:0] m_addr,
    input  logic [DW*N_CH-1:0] m_wdata,
    output logic [N_CH-1:0]    m_addr_ok,
    output logic [N_CH-1:0]    m_data_ok,
    output logic [DW-1:0]      m_rdata,
    output logic               s_req,
    output logic               s_wr,
    output logic [1:0]         s_size,
    output logic [AW-1:0]      s_addr,
    output logic [DW-1:0]      s_wdata,
    input  logic               s_addr_ok,
    input  logic               s_data_ok,
    input  logic [DW-1:0]      s_rdata,
    output logic               busy,
    output logic               err_stray
);

    localparam int IW = $clog2(N_CH);

    state_t        r_state;
    logic [IW-1:0] r_grant;
    logic [IW-1:0] r_rr_ptr;
    logic          r_err_stray;

    logic [IW-1:0] w_pick_idx;
    logic          w_pick_valid;
    logic          w_grant_req;

    sram_rr_arbiter_rr_pick #(
        .N_CH (N_CH),
        .IW   (IW)
    ) u_rr_pick (
        .i_req   (m_req),
        .i_ptr   (r_rr_ptr),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    assign w_grant_req = m_req[r_grant];

    // rr_ptr only advances on a completed transaction, so a withdrawn master keeps its turn
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_err_stray <= 1'b0;
        end else begin
            r_err_stray <= s_data_ok && (r_state != ST_DATA);
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_grant <= w_pick_idx;
                        r_state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (!w_grant_req) begin
                        r_state <= ST_IDLE;
                    end else if (s_addr_ok) begin
                        r_state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (s_data_ok) begin
                        r_rr_ptr <= (r_grant == IW'(N_CH - 1)) ? '0 : r_grant + 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Downstream fields and handshake pulses are steered only toward the granted channel
    always_comb begin
        s_req     = 1'b0;
        s_wr      = 1'b0;
        s_size    = '0;
        s_addr    = '0;
        s_wdata   = '0;
        m_addr_ok = '0;
        m_data_ok = '0;
        m_rdata   = '0;
        case (r_state)
            ST_ADDR: begin
                s_req              = w_grant_req;
                s_wr               = m_wr[r_grant];
                s_size             = m_size[2*int'(r_grant) +: 2];
                s_addr             = m_addr[AW*int'(r_grant) +: AW];
                s_wdata            = m_wdata[DW*int'(r_grant) +: DW];
                m_addr_ok[r_grant] = s_addr_ok & w_grant_req;
            end
            ST_DATA: begin
                m_data_ok[r_grant] = s_data_ok;
                if (s_data_ok) begin
                    m_rdata = s_rdata;
                end
            end
            default: ;
        endcase
    end

    assign busy      = (r_state != ST_IDLE);
    assign err_stray = r_err_stray;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Directed self-checking bench for sram_rr_arbiter with four channels.
// The slave side is either driven by hand or by a zero-wait responder.
module tb_sram_rr_arbiter;
    import sram_rr_arbiter_pkg::*;

    localparam int NCH = 4;
    localparam int AWB = 32;
    localparam int DWB = 32;

    logic              clk;
    logic              reset;
    logic [NCH-1:0]    mReq;
    logic [NCH-1:0]    mWr;
    logic [2*NCH-1:0]  mSize;
    logic [AWB*NCH-1:0] mAddr;
    logic [DWB*NCH-1:0] mWdata;
    logic [NCH-1:0]    mAddrOk;
    logic [NCH-1:0]    mDataOk;
    logic [DWB-1:0]    mRdata;
    logic              sReq;
    logic              sWr;
    logic [1:0]        sSize;
    logic [AWB-1:0]    sAddr;
    logic [DWB-1:0]    sWdata;
    logic              sAddrOk;
    logic              sDataOk;
    logic [DWB-1:0]    sRdata;
    logic              busy;
    logic              errStray;

    logic autoSlave;
    logic manualAddrOk;
    logic manualDataOk;
    logic gotAddr;

    int vectors;
    int miscompares;
    int grantLog[$];

    sram_rr_arbiter #(
        .N_CH (NCH),
        .AW   (AWB),
        .DW   (DWB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .m_req     (mReq),
        .m_wr      (mWr),
        .m_size    (mSize),
        .m_addr    (mAddr),
        .m_wdata   (mWdata),
        .m_addr_ok (mAddrOk),
        .m_data_ok (mDataOk),
        .m_rdata   (mRdata),
        .s_req     (sReq),
        .s_wr      (sWr),
        .s_size    (sSize),
        .s_addr    (sAddr),
        .s_wdata   (sWdata),
        .s_addr_ok (sAddrOk),
        .s_data_ok (sDataOk),
        .s_rdata   (sRdata),
        .busy      (busy),
        .err_stray (errStray)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Zero-wait responder: accept the address at once, return data the next cycle
    always_ff @(posedge clk) begin
        if (reset || !autoSlave) begin
            gotAddr <= 1'b0;
        end else if (sReq && sAddrOk) begin
            gotAddr <= 1'b1;
        end else if (sDataOk) begin
            gotAddr <= 1'b0;
        end
    end

    assign sAddrOk = autoSlave ? sReq : manualAddrOk;
    assign sDataOk = autoSlave ? gotAddr : manualDataOk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int ch, input logic req, input logic wr, input logic [1:0] size,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        mReq[ch]              = req;
        mWr[ch]               = wr;
        mSize[2*ch +: 2]      = size;
        mAddr[AWB*ch +: AWB]  = addr;
        mWdata[DWB*ch +: DWB] = wdata;
    endtask

    task automatic doReset();
        reset        = 1'b1;
        mReq         = '0;
        mWr          = '0;
        mSize        = '0;
        mAddr        = '0;
        mWdata       = '0;
        sRdata       = '0;
        autoSlave    = 1'b0;
        manualAddrOk = 1'b0;
        manualDataOk = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic recordGrants(input string tag, input int count, input int budget);
        grantLog.delete();
        for (int cyc = 0; cyc < budget && grantLog.size() < count; cyc++) begin
            tick();
            for (int ch = 0; ch < NCH; ch++) begin
                if (mAddrOk[ch]) grantLog.push_back(ch);
            end
        end
        checkOutput({tag, "_count"}, 64'(grantLog.size()), 64'(count));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;

        // Reset state
        reset = 1'b1;
        doReset();
        reset = 1'b1;
        settle();
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_sreq", 64'(sReq), 64'd0);
        checkOutput("rst_addrok", 64'(mAddrOk), 64'd0);
        checkOutput("rst_dataok", 64'(mDataOk), 64'd0);
        checkOutput("rst_rdata", 64'(mRdata), 64'd0);
        checkOutput("rst_stray", 64'(errStray), 64'd0);
        checkOutput("rst_saddr", 64'(sAddr), 64'd0);

        // Two masters requesting from reset exit alternate 0,1,0,1
        doReset();
        autoSlave = 1'b1;
        applyStimulus(0, 1'b1, 1'b0, SIZE_WORD, 32'h100, 32'h0);
        applyStimulus(1, 1'b1, 1'b0, SIZE_WORD, 32'h200, 32'h0);
        recordGrants("alt", 4, 40);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("alt_order%0d", i), 64'(i < grantLog.size() ? grantLog[i] : -1), 64'(i % 2));
        end

        // Single read on channel 2 with a 3-cycle data latency
        doReset();
        manualAddrOk = 1'b1;
        applyStimulus(2, 1'b1, 1'b0, SIZE_WORD, 32'h1000, 32'h0);
        tick();
        checkOutput("rd_sreq", 64'(sReq), 64'd1);
        checkOutput("rd_saddr", 64'(sAddr), 64'h1000);
        checkOutput("rd_ssize", 64'(sSize), 64'(SIZE_WORD));
        checkOutput("rd_swr", 64'(sWr), 64'd0);
        checkOutput("rd_addrok", 64'(mAddrOk), 64'b0100);
        tick();
        mReq[2]      = 1'b0;
        manualAddrOk = 1'b0;
        settle();
        checkOutput("rd_data_sreq", 64'(sReq), 64'd0);
        checkOutput("rd_data_saddr", 64'(sAddr), 64'd0);
        checkOutput("rd_data_addrok", 64'(mAddrOk), 64'd0);
        tick();
        tick();
        checkOutput("rd_wait_dataok", 64'(mDataOk), 64'd0);
        checkOutput("rd_wait_busy", 64'(busy), 64'd1);
        manualDataOk = 1'b1;
        sRdata       = 32'hDEADBEEF;
        settle();
        checkOutput("rd_dataok", 64'(mDataOk), 64'b0100);
        checkOutput("rd_rdata", 64'(mRdata), 64'hDEADBEEF);
        tick();
        manualDataOk = 1'b0;
        settle();
        checkOutput("rd_done_busy", 64'(busy), 64'd0);
        checkOutput("rd_done_rdata", 64'(mRdata), 64'd0);
        checkOutput("rd_done_stray", 64'(errStray), 64'd0);

        // Channel 1 write held steady while channel 0 waits its turn
        doReset();
        autoSlave = 1'b1;
        applyStimulus(0, 1'b1, 1'b0, SIZE_WORD, 32'h40, 32'h0);
        recordGrants("pre", 1, 10);
        tick();
        mReq[0] = 1'b0;
        tick();
        autoSlave = 1'b0;
        applyStimulus(1, 1'b1, 1'b1, SIZE_BYTE, 32'h23, 32'h55);
        mReq[0] = 1'b1;
        tick();
        checkOutput("wr_ssize", 64'(sSize), 64'(SIZE_BYTE));
        checkOutput("wr_saddr", 64'(sAddr), 64'h23);
        checkOutput("wr_swdata", 64'(sWdata), 64'h55);
        checkOutput("wr_swr", 64'(sWr), 64'd1);
        checkOutput("wr_noaddrok", 64'(mAddrOk), 64'd0);
        tick();
        checkOutput("wr_saddr_hold", 64'(sAddr), 64'h23);
        manualAddrOk = 1'b1;
        settle();
        checkOutput("wr_addrok", 64'(mAddrOk), 64'b0010);
        tick();
        mReq[1]      = 1'b0;
        manualAddrOk = 1'b0;
        tick();
        manualDataOk = 1'b1;
        settle();
        checkOutput("wr_dataok", 64'(mDataOk), 64'b0010);
        tick();
        manualDataOk = 1'b0;
        settle();
        checkOutput("wr_idle_addrok", 64'(mAddrOk), 64'd0);
        tick();
        manualAddrOk = 1'b1;
        settle();
        checkOutput("next_saddr", 64'(sAddr), 64'h40);
        checkOutput("next_addrok", 64'(mAddrOk), 64'b0001);

        // Reset during DATA abandons the transaction; the late data only flags a stray
        doReset();
        manualAddrOk = 1'b1;
        applyStimulus(3, 1'b1, 1'b0, SIZE_WORD, 32'h80, 32'h0);
        tick();
        tick();
        mReq[3]      = 1'b0;
        manualAddrOk = 1'b0;
        settle();
        checkOutput("abn_busy_data", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        checkOutput("abn_busy_rst", 64'(busy), 64'd0);
        tick();
        tick();
        manualDataOk = 1'b1;
        sRdata       = 32'h1234;
        settle();
        checkOutput("abn_dataok", 64'(mDataOk), 64'd0);
        checkOutput("abn_rdata", 64'(mRdata), 64'd0);
        tick();
        manualDataOk = 1'b0;
        settle();
        checkOutput("abn_stray", 64'(errStray), 64'd1);
        checkOutput("abn_busy", 64'(busy), 64'd0);
        tick();
        checkOutput("abn_stray_end", 64'(errStray), 64'd0);

        // Withdrawal in ADDR keeps the pointer; stray data in ADDR is ignored but flagged
        doReset();
        applyStimulus(0, 1'b1, 1'b0, SIZE_HALF, 32'h10, 32'h0);
        tick();
        checkOutput("wd_sreq", 64'(sReq), 64'd1);
        manualDataOk = 1'b1;
        settle();
        checkOutput("wd_stray_dataok", 64'(mDataOk), 64'd0);
        tick();
        manualDataOk = 1'b0;
        settle();
        checkOutput("wd_stray", 64'(errStray), 64'd1);
        checkOutput("wd_still_addr", 64'(busy), 64'd1);
        mReq[0] = 1'b0;
        settle();
        checkOutput("wd_sreq_drop", 64'(sReq), 64'd0);
        tick();
        checkOutput("wd_idle", 64'(busy), 64'd0);
        mReq[0]      = 1'b1;
        applyStimulus(1, 1'b1, 1'b0, SIZE_WORD, 32'h20, 32'h0);
        manualAddrOk = 1'b1;
        tick();
        checkOutput("wd_regrant", 64'(mAddrOk), 64'b0001);

        // All four channels requesting continuously for 16 transactions
        doReset();
        autoSlave = 1'b1;
        mReq      = 4'b1111;
        recordGrants("all", 16, 100);
        begin
            int served[NCH];
            int lastAt[NCH];
            int maxWait;
            maxWait = 0;
            for (int ch = 0; ch < NCH; ch++) begin
                served[ch] = 0;
                lastAt[ch] = -1;
            end
            for (int i = 0; i < grantLog.size(); i++) begin
                int ch;
                ch = grantLog[i];
                served[ch]++;
                if (i - lastAt[ch] > maxWait) maxWait = i - lastAt[ch];
                lastAt[ch] = i;
                checkOutput($sformatf("all_order%0d", i), 64'(ch), 64'(i % NCH));
            end
            for (int ch = 0; ch < NCH; ch++) begin
                checkOutput($sformatf("all_served%0d", ch), 64'(served[ch]), 64'd4);
            end
            checkOutput("all_maxwait_le4", 64'(maxWait <= NCH), 64'd1);
        end

        mReq      = '0;
        autoSlave = 1'b0;
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sram_rr_arbiter.md
SRAM_RR_ARBITER -- requirements
Module: sram_rr_arbiter

Interface
REQ-001 Parameter N_CH, default 2, SHALL set the number of upstream SRAM-like master channels (2..8).
REQ-002 Parameter AW, default 32, SHALL set the address width.
REQ-003 Parameter DW, default 32, SHALL set the data width.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 m_req  in  N_CH  per-channel request.
REQ-007 m_wr  in  N_CH  per-channel write flag.
REQ-008 m_size  in  2*N_CH  per-channel size, channel i at [2i+1:2i].
REQ-009 m_addr  in  AW*N_CH  per-channel address.
REQ-010 m_wdata  in  DW*N_CH  per-channel write data.
REQ-011 m_addr_ok  out  N_CH  per-channel address-accepted pulse.
REQ-012 m_data_ok  out  N_CH  per-channel data-done pulse.
REQ-013 m_rdata  out  DW  shared read data, valid for the channel whose m_data_ok bit is high.
REQ-014 s_req, s_wr, s_size[1:0], s_addr[AW-1:0], s_wdata[DW-1:0]  out  downstream SRAM-like request.
REQ-015 s_addr_ok, s_data_ok  in  1; s_rdata  in  DW  downstream responses.
REQ-016 busy  out  1  high whenever state is not IDLE.
REQ-017 err_stray  out  1  one-cycle pulse when s_data_ok arrives with no outstanding transaction.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, ADDR, DATA, with one outstanding transaction at most.
REQ-019 IDLE: if any m_req bit is set, grant SHALL be registered to the first requesting channel at or after rr_ptr (wrapping N_CH-1 -> 0), and the FSM SHALL go to ADDR; otherwise remain in IDLE.
REQ-020 ADDR: s_req SHALL equal m_req[grant]; s_wr/s_size/s_addr/s_wdata SHALL be the granted channel's fields (combinational mux); m_addr_ok[grant] = s_addr_ok; on s_req & s_addr_ok go to DATA.
REQ-021 ADDR with m_req[grant] deasserted (master withdrew) SHALL return to IDLE without advancing rr_ptr.
REQ-022 DATA: s_req SHALL be 0; on s_data_ok, m_data_ok[grant] SHALL pulse in the same cycle, m_rdata = s_rdata, rr_ptr SHALL become (grant+1) mod N_CH, and the FSM SHALL go to IDLE.
REQ-023 Latency: request seen in IDLE at cycle t -> s_req high at t+1; minimum transaction 3 cycles (IDLE, ADDR, DATA), one IDLE bubble between back-to-back grants.
REQ-024 m_addr_ok and m_data_ok bits of non-granted channels SHALL be 0 at all times; in IDLE all SHALL be 0.
REQ-025 Grant SHALL NOT change between ADDR entry and DATA exit regardless of other requests.
REQ-026 s_data_ok in IDLE or ADDR SHALL be ignored functionally and SHALL pulse err_stray for one cycle.
REQ-027 s_addr_ok outside ADDR SHALL be ignored.
REQ-028 Starvation bound: a continuously requesting channel SHALL be granted within N_CH grants.
REQ-029 Outside ADDR, s_wr/s_size/s_addr/s_wdata SHALL be 0.
REQ-030 m_rdata SHALL be 0 when no m_data_ok bit is high.

Reset
REQ-031 On reset: state = IDLE, grant = 0, rr_ptr = 0, err_stray = 0; all outputs therefore 0.
REQ-032 Reset mid-transaction SHALL abandon it; a later downstream s_data_ok for it SHALL only raise err_stray.

Structure
REQ-033 State encoding (IDLE=0, ADDR=1, DATA=2) and SRAM size codes (byte=0, half=1, word=2) SHALL live in a shared package.
REQ-034 One sub-module, rr_pick (combinational round-robin first-set-from-pointer, parametrised by N_CH), SHALL provide the grant index.

Verification
REQ-035 N_CH=2, m_req=2'b11 at reset exit, 0-wait slave -> ch0 granted, then ch1; grant order 0,1,0,1 over 4 transactions.
REQ-036 N_CH=4, only ch2 requests read addr 0x1000, slave returns 0xDEADBEEF after 3 cycles -> m_addr_ok[2] one pulse, m_data_ok[2] one pulse with m_rdata=0xDEADBEEF, others 0.
REQ-037 Ch1 write size=0 addr 0x23 wdata 0x55 while ch0 requests -> s_size=0, s_addr=0x23 unchanged until data_ok; ch0 served next.
REQ-038 Reset asserted during DATA, s_data_ok arrives 2 cycles after release -> no m_data_ok, err_stray one pulse, busy=0.
REQ-039 Ch0 drops m_req in ADDR before s_addr_ok -> return to IDLE, rr_ptr stays 0, ch0 re-granted if it requests again.
REQ-040 N_CH=4, all channels request continuously for 16 transactions -> each served exactly 4 times, max wait 4 grants.
